// File: rtl/branch_table_loader.sv
// Label-indexed branch target table, filled from a byte stream of (label, target) records
// and read combinationally by the fetch stage.
module branch_table_loader #(
  parameter int DEPTH = 64,
  parameter int PC_W  = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  input  logic [7:0]                 lookup_label,
  output logic [PC_W-1:0]            next_pc,
  output logic                       hit,
  output logic                       load_done,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     entry_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_LABEL  = 3'd0,
    S_HI     = 3'd1,
    S_LO     = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q;
  logic [7:0]        label_q;
  logic [3:0]        hi_q;
  logic [7:0]        lo_q;
  logic              bad_q;
  logic              in_ready_q;
  logic              load_done_q;
  logic              err_q;
  logic [CW-1:0]     entry_count_q;
  logic [DEPTH-1:0]  valid_q;
  logic [PC_W-1:0]   tgt_q [DEPTH];

  logic              xfer;
  logic              label_ok;
  logic              commit_we;

  assign xfer      = in_valid && in_ready_q;
  assign label_ok  = ({1'b0, label_q} < DEPTH_LIM);
  assign commit_we = (state_q == S_COMMIT) && !clear && label_ok && !bad_q;

  // Record-parsing FSM with its registered handshake, status and valid-bit state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_LABEL;
      label_q       <= 8'd0;
      hi_q          <= 4'd0;
      lo_q          <= 8'd0;
      bad_q         <= 1'b0;
      in_ready_q    <= 1'b1;
      load_done_q   <= 1'b0;
      err_q         <= 1'b0;
      entry_count_q <= '0;
      valid_q       <= '0;
    end else if (clear) begin
      state_q       <= S_LABEL;
      bad_q         <= 1'b0;
      in_ready_q    <= 1'b1;
      load_done_q   <= 1'b0;
      err_q         <= 1'b0;
      entry_count_q <= '0;
      valid_q       <= '0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        S_LABEL: begin
          if (xfer) begin
            if (in_data == 8'hFF) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              label_q <= in_data;
              bad_q   <= 1'b0;
              state_q <= S_HI;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_q    <= in_data[3:0];
            state_q <= S_LO;
            if (in_data[7:4] != 4'd0) begin
              err_q <= 1'b1;
              bad_q <= 1'b1;
            end
          end
        end
        S_LO: begin
          if (xfer) begin
            lo_q       <= in_data;
            state_q    <= S_COMMIT;
            in_ready_q <= 1'b0;
          end
        end
        S_COMMIT: begin
          // A bad nibble has already flagged err; only out-of-range labels flag it here.
          if (commit_we) begin
            valid_q[label_q[AW-1:0]] <= 1'b1;
            if (!valid_q[label_q[AW-1:0]]) begin
              entry_count_q <= entry_count_q + CW'(1);
            end
          end else if (!label_ok) begin
            err_q <= 1'b1;
          end
          state_q    <= S_LABEL;
          in_ready_q <= 1'b1;
        end
        S_DONE: begin
          state_q    <= S_DONE;
          in_ready_q <= 1'b0;
        end
        default: begin
          state_q    <= S_LABEL;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Target storage; contents are qualified by valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    if (commit_we) begin
      tgt_q[label_q[AW-1:0]] <= PC_W'({hi_q, lo_q});
    end
  end

  // Combinational lookup for the fetch stage.
  always_comb begin
    hit     = 1'b0;
    next_pc = '0;
    if (({1'b0, lookup_label} < DEPTH_LIM) && valid_q[lookup_label[AW-1:0]]) begin
      hit     = 1'b1;
      next_pc = tgt_q[lookup_label[AW-1:0]];
    end else begin
      hit     = 1'b0;
      next_pc = '0;
    end
  end

  assign in_ready    = in_ready_q;
  assign load_done   = load_done_q;
  assign err         = err_q;
  assign entry_count = entry_count_q;

endmodule

// File: tb/tb_branch_table_loader.sv
// Scoreboard bench for branch_table_loader: expected lookups are queued as records are
// streamed in and drained against the combinational lookup port.
module tb_branch_table_loader;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  lookup_label;
  logic [11:0] next_pc;
  logic        hit;
  logic        load_done;
  logic        err;
  logic [6:0]  entry_count;

  int n_checks;
  int n_fails;

  typedef struct {
    logic [7:0]  label;
    logic [11:0] pc;
    logic        hit;
  } exp_t;

  exp_t sb_q[$];

  branch_table_loader #(.DEPTH(64), .PC_W(12)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .lookup_label (lookup_label),
    .next_pc      (next_pc),
    .hit          (hit),
    .load_done    (load_done),
    .err          (err),
    .entry_count  (entry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_lookup(input logic [7:0] label, input logic [11:0] pc, input logic h);
    exp_t e;
    e.label = label;
    e.pc    = pc;
    e.hit   = h;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      lookup_label = e.label;
      #1;
      check_eq($sformatf("hit[%0d]", e.label), 32'(hit), 32'(e.hit));
      check_eq($sformatf("next_pc[%0d]", e.label), 32'(next_pc), 32'(e.pc));
    end
  endtask

  // Offer one byte and hold it until accepted, bounded by a cycle budget.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Full record; in_ready must drop for exactly the commit cycle.
  task automatic send_record(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    check_eq("ready_commit", 32'(in_ready), 32'd0);
    tick();
    check_eq("ready_after_commit", 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    reset_n      = 1'b0;
    clear        = 1'b0;
    in_valid     = 1'b0;
    in_data      = 8'd0;
    lookup_label = 8'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_count", 32'(entry_count), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_done", 32'(load_done), 32'd0);
    push_lookup(8'd0, 12'd0, 1'b0);
    push_lookup(8'd5, 12'd0, 1'b0);
    push_lookup(8'd200, 12'd0, 1'b0);
    drain();

    // Two fresh records
    send_record(8'd18, 8'h00, 8'h08);
    push_lookup(8'd18, 12'd8, 1'b1);
    drain();
    send_record(8'd2, 8'h01, 8'h43);
    push_lookup(8'd2, 12'd323, 1'b1);
    push_lookup(8'd18, 12'd8, 1'b1);
    drain();
    check_eq("count_two", 32'(entry_count), 32'd2);

    // Overwrite label 18, checking the commit-cycle lookup sees the old value
    send_byte(8'd18);
    send_byte(8'h02);
    send_byte(8'h6C);
    lookup_label = 8'd18;
    #1;
    check_eq("commit_old_pc", 32'(next_pc), 32'd8);
    check_eq("commit_old_hit", 32'(hit), 32'd1);
    tick();
    check_eq("after_commit_pc", 32'(next_pc), 32'd620);
    push_lookup(8'd18, 12'd620, 1'b1);
    drain();
    check_eq("count_overwrite", 32'(entry_count), 32'd2);
    check_eq("err_clean", 32'(err), 32'd0);

    // Out-of-range label
    send_record(8'd70, 8'h00, 8'h01);
    check_eq("err_range", 32'(err), 32'd1);
    check_eq("count_range", 32'(entry_count), 32'd2);
    push_lookup(8'd70, 12'd0, 1'b0);
    drain();
    send_record(8'd3, 8'h00, 8'hC9);
    push_lookup(8'd3, 12'd201, 1'b1);
    drain();
    check_eq("err_sticky", 32'(err), 32'd1);
    check_eq("count_three", 32'(entry_count), 32'd3);

    // Bad high byte, then terminator
    send_record(8'd9, 8'h10, 8'h55);
    push_lookup(8'd9, 12'd0, 1'b0);
    drain();
    check_eq("count_bad", 32'(entry_count), 32'd3);
    send_byte(8'hFF);
    check_eq("load_done_pulse", 32'(load_done), 32'd1);
    check_eq("done_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'd7;
    tick();
    check_eq("load_done_once", 32'(load_done), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("done_hold%0d", i), 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    push_lookup(8'd18, 12'd620, 1'b1);
    push_lookup(8'd7, 12'd0, 1'b0);
    drain();
    check_eq("count_frozen", 32'(entry_count), 32'd3);

    // Reset mid-record
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    send_byte(8'd5);
    send_byte(8'h00);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    send_record(8'd4, 8'h00, 8'hD4);
    push_lookup(8'd4, 12'd212, 1'b1);
    push_lookup(8'd5, 12'd0, 1'b0);
    push_lookup(8'd18, 12'd0, 1'b0);
    drain();
    check_eq("rst_mid_count", 32'(entry_count), 32'd1);
    check_eq("rst_mid_err", 32'(err), 32'd0);

    // Clear mid-record, with a byte offered in the clear cycle
    send_record(8'd10, 8'h00, 8'h11);
    send_byte(8'd6);
    send_byte(8'h00);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_eq("clr_count", 32'(entry_count), 32'd0);
    check_eq("clr_ready", 32'(in_ready), 32'd1);
    send_record(8'd4, 8'h00, 8'hD4);
    push_lookup(8'd4, 12'd212, 1'b1);
    push_lookup(8'd6, 12'd0, 1'b0);
    push_lookup(8'd10, 12'd0, 1'b0);
    drain();
    check_eq("clr_mid_count", 32'(entry_count), 32'd1);
    check_eq("clr_mid_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
